seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Sequential ALU that consumes the 3-bit opcode from the one-hot function encoder.
//  It latches the opcode and two operands over a valid/ready handshake and executes the operation.
//  It holds the result until the downstream stage accepts it.
//  Single-cycle ops finish in 1 cycle. MUL is an iterative shift-add multiplier taking WIDTH cycles.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      opcode/a/b valid
//  in_ready   out  1      block can accept an operation (IDLE only)
//  opcode     in   3      operation select (from encoder)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  result
//  carry      out  1      carry/borrow/overflow flag
//  zero       out  1      1 when result == 0
// BEHAVIOUR
//  Clocking and reset
//   - One clock domain.
//   - Reset is asynchronous and active-high.
//   - Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=0, internal regs=0.
//   - Reset asserted in any state, including mid-MUL, aborts the operation immediately.
//   - No result is emitted for an aborted operation.
//  States
//   - IDLE: in_ready=1.
//     - in_valid&&in_ready latches opcode, a, b.
//     - MUL -> EXEC. All other opcodes -> DONE, with result computed at the same edge.
//   - EXEC: in_ready=0. One shift-add step per cycle, counter 0..WIDTH-1.
//     - After step WIDTH-1 -> DONE.
//   - DONE: out_valid=1, in_ready=0.
//     - result/carry/zero stay stable while out_ready=0.
//     - out_valid&&out_ready -> IDLE; out_valid=0 and in_ready=1 on the next cycle.
//  Latency and ignored inputs
//   - Latency from accept edge to out_valid: 1 cycle for non-MUL ops; WIDTH+1 cycles for MUL.
//   - in_valid is ignored outside IDLE.
//   - No operation is accepted in the same cycle as the output handshake.
//  Opcodes (all results taken mod 2^WIDTH)
//   - 000 ADD: a+b. carry = carry-out.
//   - 001 SUB: a-b. carry = borrow (a<b).
//   - 010 AND, 011 OR, 100 XOR: carry=0.
//   - 101 NOT: ~a. carry=0.
//   - 110 SHL: {a[WIDTH-2:0],1'b0}. carry = a[WIDTH-1].
//   - 111 MUL: low WIDTH bits of the 2*WIDTH-bit a*b. carry = 1 if the upper half is nonzero.
//  Flags and output registers
//   - zero reflects the final result of every opcode.
//   - result/carry/zero update only on transition into DONE.
//   - In IDLE/EXEC they keep the last delivered values; these are don't-care while out_valid=0.
// TESTING (WIDTH=8)
//  1. Reset: after reset, in_ready=1, out_valid=0, result=0x00, carry=0, zero=0.
//     Reset deassert -> no spurious out_valid.
//  2. ADD a=0xF0 b=0x20, out_ready=1 -> out_valid 1 cycle after accept, result=0x10, carry=1, zero=0.
//     in_ready=1 on the following cycle.
//  3. SUB 0x05-0x05 -> result=0x00, zero=1, carry=0.
//     SUB 0x03-0x05 -> result=0xFE, carry=1, zero=0.
//  4. MUL 0x10*0x11 -> out_valid exactly 9 cycles after accept, result=0x10, carry=1.
//     in_ready=0 throughout; an in_valid pulse mid-EXEC is ignored.
//  5. Backpressure: after XOR 0xAA^0xFF, hold out_ready=0 for 5 cycles.
//     result=0x55 stays stable with out_valid=1, and in_valid pulses are ignored.
//     Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
//  6. Reset asserted on the 4th EXEC cycle of MUL 0xFF*0xFF.
//     -> out_valid=0 and in_ready=1 immediately (async).
//     The next accepted ADD 0x01+0x01 returns result=0x02.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready input and output handshakes.
// Single-cycle ops resolve at the accept edge; MUL runs an iterative
// shift-add over WIDTH cycles. The result is held until downstream accepts it.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_step;

    // Handshake outputs decode directly from state so an async reset takes effect at once.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // Single-cycle operation result and carry, computed from the live inputs at accept.
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_t'(opcode))
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res   = {a[WIDTH-2:0], 1'b0};
                alu_carry = a[WIDTH-1];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (op_t'(opcode) == OP_MUL) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, multiply steps, and output register updates on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op_t'(opcode) == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else begin
                            result <= alu_res;
                            carry  <= alu_carry;
                            zero   <= (alu_res == '0);
                        end
                    end
                end
                EXEC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // The final partial product is folded in combinationally so the
                    // result lands on the same edge as the move to DONE.
                    if (last_step) begin
                        result <= acc_next[WIDTH-1:0];
                        carry  <= |acc_next[2*WIDTH-1:WIDTH];
                        zero   <= (acc_next[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    int vectors;
    int miscompares;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 3'b000;
        a         = 8'h00;
        b         = 8'h00;
        step();
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h00 || carry !== 1'b0 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vals: got rdy=%b ov=%b res=%h c=%b z=%b, want rdy=1 ov=0 res=00 c=0 z=0",
                     in_ready, out_valid, result, carry, zero);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_idle: cyc %0d got ov=%b rdy=%b, want ov=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_add();
        opcode    = 3'b000;
        a         = 8'hF0;
        b         = 8'h20;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || result !== 8'h10 || carry !== 1'b1 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL add_f0_20: got ov=%b res=%h c=%b z=%b, want ov=1 res=10 c=1 z=0",
                     out_valid, result, carry, zero);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL add_release: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    // Table of single-cycle ops: {opcode, a, b, result, carry, zero}.
    task automatic test_single_ops();
        logic [2:0] t_op  [9];
        logic [7:0] t_a   [9];
        logic [7:0] t_b   [9];
        logic [7:0] t_res [9];
        logic       t_c   [9];
        logic       t_z   [9];
        t_op[0] = 3'b001; t_a[0] = 8'h05; t_b[0] = 8'h05; t_res[0] = 8'h00; t_c[0] = 1'b0; t_z[0] = 1'b1;
        t_op[1] = 3'b001; t_a[1] = 8'h03; t_b[1] = 8'h05; t_res[1] = 8'hFE; t_c[1] = 1'b1; t_z[1] = 1'b0;
        t_op[2] = 3'b010; t_a[2] = 8'hF0; t_b[2] = 8'h3C; t_res[2] = 8'h30; t_c[2] = 1'b0; t_z[2] = 1'b0;
        t_op[3] = 3'b011; t_a[3] = 8'hF0; t_b[3] = 8'h0F; t_res[3] = 8'hFF; t_c[3] = 1'b0; t_z[3] = 1'b0;
        t_op[4] = 3'b100; t_a[4] = 8'h5A; t_b[4] = 8'h5A; t_res[4] = 8'h00; t_c[4] = 1'b0; t_z[4] = 1'b1;
        t_op[5] = 3'b101; t_a[5] = 8'hFF; t_b[5] = 8'h12; t_res[5] = 8'h00; t_c[5] = 1'b0; t_z[5] = 1'b1;
        t_op[6] = 3'b101; t_a[6] = 8'h0F; t_b[6] = 8'h00; t_res[6] = 8'hF0; t_c[6] = 1'b0; t_z[6] = 1'b0;
        t_op[7] = 3'b110; t_a[7] = 8'h81; t_b[7] = 8'h00; t_res[7] = 8'h02; t_c[7] = 1'b1; t_z[7] = 1'b0;
        t_op[8] = 3'b000; t_a[8] = 8'h7F; t_b[8] = 8'h01; t_res[8] = 8'h80; t_c[8] = 1'b0; t_z[8] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            opcode   = t_op[i];
            a        = t_a[i];
            b        = t_b[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || result !== t_res[i] || carry !== t_c[i] || zero !== t_z[i]) begin
                miscompares++;
                $display("FAIL op_%0d (opc %b %h,%h): got ov=%b res=%h c=%b z=%b, want ov=1 res=%h c=%b z=%b",
                         i, t_op[i], t_a[i], t_b[i], out_valid, result, carry, zero, t_res[i], t_c[i], t_z[i]);
            end
            step();
        end
    endtask

    // Run one MUL, checking latency in cycles from the accept cycle and in_ready low throughout.
    task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb,
                           input logic [7:0] eres, input logic ec, input logic ez, input bit pulse);
        int n;
        opcode    = 3'b111;
        a         = ma;
        b         = mb;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 30) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_in_ready: cyc %0d got rdy=%b, want 0", n, in_ready);
            end
            if (pulse && n == 3) begin
                opcode   = 3'b000;
                a        = 8'h01;
                b        = 8'h01;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL mul_latency %h*%h: got %0d cycles, want 9", ma, mb, n);
        end
        vectors++;
        if (out_valid !== 1'b1 || result !== eres || carry !== ec || zero !== ez) begin
            miscompares++;
            $display("FAIL mul_result %h*%h: got ov=%b res=%h c=%b z=%b, want ov=1 res=%h c=%b z=%b",
                     ma, mb, out_valid, result, carry, zero, eres, ec, ez);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_release: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_mul();
        run_mul(8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b1);
        run_mul(8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0);
        run_mul(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        run_mul(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        opcode    = 3'b100;
        a         = 8'hAA;
        b         = 8'hFF;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h55 || carry !== 1'b0 || zero !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: cyc %0d got ov=%b rdy=%b res=%h c=%b z=%b, want ov=1 rdy=0 res=55 c=0 z=0",
                         i, out_valid, in_ready, result, carry, zero);
            end
            opcode   = 3'b000;
            a        = 8'hFF;
            b        = 8'hFF;
            in_valid = (i % 2 == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    // Output handshake cycle with in_valid high must not also accept a new op.
    task automatic test_back_to_back();
        opcode    = 3'b000;
        a         = 8'h02;
        b         = 8'h03;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        a = 8'h10;
        b = 8'h20;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h05) begin
            miscompares++;
            $display("FAIL b2b_gap: got ov=%b rdy=%b res=%h, want ov=0 rdy=1 res=05", out_valid, in_ready, result);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || result !== 8'h30) begin
            miscompares++;
            $display("FAIL b2b_second: got ov=%b res=%h, want ov=1 res=30", out_valid, result);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        opcode    = 3'b111;
        a         = 8'hFF;
        b         = 8'hFF;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_async: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
        step();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_result: cyc %0d got ov=%b, want 0", i, out_valid);
            end
        end
        opcode   = 3'b000;
        a        = 8'h01;
        b        = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || result !== 8'h02 || carry !== 1'b0 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next_add: got ov=%b res=%h c=%b z=%b, want ov=1 res=02 c=0 z=0",
                     out_valid, result, carry, zero);
        end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_single_ops();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
